regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback requesters: the ALU result path (req A) and the load/memory path (req B). It arbitrates round-robin, registers the winning write and drives the register file's regWrite/writeReg/writeData. It sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
hold  input  1  when high, no grants are issued (pipeline freeze)
aValid  input  1  ALU requester has a write pending
aReg  input  ADDR_W  ALU destination register
aData  input  DATA_W  ALU write data
aReady  output  1  ALU request granted this cycle
bValid  input  1  memory requester has a write pending
bReg  input  ADDR_W  memory destination register
bData  input  DATA_W  memory write data
bReady  output  1  memory request granted this cycle
regWrite  output  1  write enable to the register file
writeReg  output  ADDR_W  register file write index
writeData  output  DATA_W  register file write data
fwdAddr1  input  ADDR_W  rs index for bypass lookup
fwdAddr2  input  ADDR_W  rt index for bypass lookup
fwdHit1  output  1  rs matches the in-flight write
fwdHit2  output  1  rt matches the in-flight write
fwdData1  output  DATA_W  bypass data for rs
fwdData2  output  DATA_W  bypass data for rt

Behaviour:
- Reset (async, any time): regWrite=0, writeReg=0, writeData=0, prio=A. An in-flight registered write is discarded. aReady, bReady and fwdHit* are 0 while rst is high.
- Handshake: a transfer occurs when xValid && xReady in the same cycle. The requester holds xValid, xReg and xData stable until it sees xReady. xReady is combinational from the valids, hold and prio. It never depends on the register-file side, which never stalls.
- Grant:
  - hold=1: no grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by prio is granted.
  - At most one grant per cycle.
- Priority pointer (1-bit state, A or B): after any grant, prio points to the requester that was not granted. With no grant, prio is unchanged.
- Output stage latency is 1 cycle.
  - On a grant, the next edge sets regWrite=1 and loads writeReg and writeData from the winner.
  - With no grant, the next edge sets regWrite=0; writeReg and writeData hold their values.
- Writes to register 0 are forwarded unchanged; this block applies no special treatment.
- Same destination from both requesters in the same cycle: they are serialised in round-robin order. The later-granted value is the final register content.
- Back-to-back: a requester may be granted on consecutive cycles if the other is idle. Throughput is 1 write per cycle.
- hold asserted mid-stream: the grant stops the same cycle. regWrite falls the next edge. Requests remain pending.

Optional Feature:
WB_FWD_EN
- Defined: fwdHitN = regWrite && (writeReg == fwdAddrN), and fwdDataN = writeData on a hit, else 0. This lets the decode stage bypass the write being committed this cycle.
- Undefined: the fwd* ports still exist. fwdHit1, fwdHit2, fwdData1 and fwdData2 are tied to 0, and the fwdAddr inputs are ignored.

Decomposition:
- Shared package: DATA_W and ADDR_W defaults, plus the requester-select encoding (REQ_A=1'b0, REQ_B=1'b1) used by prio and the grant mux.
- One natural sub-module, rr_arb2: the 2-way round-robin grant and pointer logic, including hold. The top level holds the output register and the optional bypass compare.

Test Plan:
- Reset: assert rst mid-write with regWrite=1 -> outputs go to 0 immediately (async). After release, aValid only gives aReady=1 the same cycle.
- Single requester: aValid=1, aReg=3, aData=0x0000_00AA -> aReady=1 that cycle. Next cycle regWrite=1, writeReg=3, writeData=0xAA.
- Contention: aValid and bValid held for 4 cycles (A: r4=0x11, B: r5=0x22) -> grant order A, B. A is granted in cycle 1 and drops valid. regWrite pulses r4, then r5, one per cycle.
- Same destination: A r7=0x1, B r7=0x2, both valid with prio=B -> B is granted first, then A. Final writes are r7=0x2 then r7=0x1.
- Hold: both valid, hold=1 for 3 cycles -> aReady=bReady=0 and regWrite=0 from the 2nd cycle. After release, grants resume with the prio held from before the hold.
- WB_FWD_EN: regWrite=1, writeReg=9, writeData=0xDEAD_BEEF, fwdAddr1=9, fwdAddr2=8 -> fwdHit1=1, fwdData1=0xDEADBEEF, fwdHit2=0, fwdData2=0. With the macro undefined, all fwd outputs are 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and requester-select encoding for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant with a one-bit priority pointer and a freeze input.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hold,
  input  logic     aValid,
  input  logic     bValid,
  output logic     aGrant,
  output logic     bGrant,
  output req_sel_e winner
);

  req_sel_e prioQ;
  req_sel_e prioD;

  // Grants are suppressed during reset so no transfer is seen by a requester.
  always_comb begin
    aGrant = 1'b0;
    bGrant = 1'b0;
    if (!rst && !hold) begin
      aGrant = aValid && (!bValid || (prioQ == REQ_A));
      bGrant = bValid && (!aValid || (prioQ == REQ_B));
    end
  end

  always_comb begin
    prioD = prioQ;
    if (aGrant) begin
      prioD = REQ_B;
    end else if (bGrant) begin
      prioD = REQ_A;
    end
  end

  assign winner = bGrant ? REQ_B : REQ_A;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prioQ <= REQ_A;
    end else begin
      prioQ <= prioD;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port with a registered write stage.
// Optional decode bypass of the committing write is enabled by defining WB_FWD_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              aValid,
  input  logic [ADDR_W-1:0] aReg,
  input  logic [DATA_W-1:0] aData,
  output logic              aReady,
  input  logic              bValid,
  input  logic [ADDR_W-1:0] bReg,
  input  logic [DATA_W-1:0] bData,
  output logic              bReady,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] fwdAddr1,
  input  logic [ADDR_W-1:0] fwdAddr2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2
);

  logic              aGrant;
  logic              bGrant;
  req_sel_e          winner;
  logic              regWriteQ;
  logic              regWriteD;
  logic [ADDR_W-1:0] writeRegQ;
  logic [ADDR_W-1:0] writeRegD;
  logic [DATA_W-1:0] writeDataQ;
  logic [DATA_W-1:0] writeDataD;

  rr_arb2 uArb (
    .clk    (clk),
    .rst    (rst),
    .hold   (hold),
    .aValid (aValid),
    .bValid (bValid),
    .aGrant (aGrant),
    .bGrant (bGrant),
    .winner (winner)
  );

  assign aReady = aGrant;
  assign bReady = bGrant;

  // Index and data hold their last value when nothing is granted.
  always_comb begin
    regWriteD  = aGrant || bGrant;
    writeRegD  = writeRegQ;
    writeDataD = writeDataQ;
    if (aGrant || bGrant) begin
      writeRegD  = (winner == REQ_B) ? bReg : aReg;
      writeDataD = (winner == REQ_B) ? bData : aData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else begin
      regWriteQ  <= regWriteD;
      writeRegQ  <= writeRegD;
      writeDataQ <= writeDataD;
    end
  end

  assign regWrite  = regWriteQ;
  assign writeReg  = writeRegQ;
  assign writeData = writeDataQ;

`ifdef WB_FWD_EN
  assign fwdHit1  = regWriteQ && (writeRegQ == fwdAddr1);
  assign fwdHit2  = regWriteQ && (writeRegQ == fwdAddr2);
  assign fwdData1 = fwdHit1 ? writeDataQ : '0;
  assign fwdData2 = fwdHit2 ? writeDataQ : '0;
`else
  logic unusedFwdAddr;
  assign unusedFwdAddr = ^{fwdAddr1, fwdAddr2};
  assign fwdHit1  = 1'b0;
  assign fwdHit2  = 1'b0;
  assign fwdData1 = '0;
  assign fwdData2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected values are hand-derived from the block's behaviour.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        aValid;
  logic [4:0]  aReg;
  logic [31:0] aData;
  logic        aReady;
  logic        bValid;
  logic [4:0]  bReg;
  logic [31:0] bData;
  logic        bReady;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  fwdAddr1;
  logic [4:0]  fwdAddr2;
  logic        fwdHit1;
  logic        fwdHit2;
  logic [31:0] fwdData1;
  logic [31:0] fwdData2;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .aValid    (aValid),
    .aReg      (aReg),
    .aData     (aData),
    .aReady    (aReady),
    .bValid    (bValid),
    .bReg      (bReg),
    .bData     (bData),
    .bReady    (bReady),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .fwdAddr1  (fwdAddr1),
    .fwdAddr2  (fwdAddr2),
    .fwdHit1   (fwdHit1),
    .fwdHit2   (fwdHit2),
    .fwdData1  (fwdData1),
    .fwdData2  (fwdData2)
  );

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br, input logic [31:0] bd,
                               input logic h);
    aValid = av;
    aReg   = ar;
    aData  = ad;
    bValid = bv;
    bReg   = br;
    bData  = bd;
    hold   = h;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    checkOutput({tag, "_regWrite"}, {31'd0, regWrite}, {31'd0, we});
    checkOutput({tag, "_writeReg"}, {27'd0, writeReg}, {27'd0, wr});
    checkOutput({tag, "_writeData"}, writeData, wd);
  endtask

  task automatic checkReady(input string tag, input logic ar, input logic br);
    checkOutput({tag, "_aReady"}, {31'd0, aReady}, {31'd0, ar});
    checkOutput({tag, "_bReady"}, {31'd0, bReady}, {31'd0, br});
  endtask

  initial begin
    rst      = 1'b1;
    fwdAddr1 = 5'd0;
    fwdAddr2 = 5'd0;
    applyStimulus(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    checkWrite("reset", 1'b0, 5'd0, 32'h0);
    checkReady("resetReady", 1'b0, 1'b0);

    // Single requester A r3 = 0xAA
    @(negedge clk);
    rst = 1'b0;
    #1 checkReady("singleA", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("singleA", 1'b1, 5'd3, 32'h0000_00AA);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h55, 1'b0);
    #1 checkReady("singleB", 1'b0, 1'b1);
    @(negedge clk);
    checkWrite("singleB", 1'b1, 5'd1, 32'h55);

    // Contention with prio back at A
    applyStimulus(1'b1, 5'd4, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0);
    #1 checkReady("cont1", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("cont1", 1'b1, 5'd4, 32'h11);
    aValid = 1'b0;
    #1 checkReady("cont2", 1'b0, 1'b1);
    @(negedge clk);
    checkWrite("cont2", 1'b1, 5'd5, 32'h22);
    bValid = 1'b0;
    #1 checkReady("idle", 1'b0, 1'b0);
    @(negedge clk);
    checkWrite("idle", 1'b0, 5'd5, 32'h22);

    // Hold mid-stream: prio is B when hold begins and must survive it
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 32'h77, 1'b0);
    #1 checkReady("preHold", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("preHold", 1'b1, 5'd6, 32'h66);
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd2, 32'h77, 1'b1);
    #1 checkReady("hold1", 1'b0, 1'b0);
    @(negedge clk);
    checkWrite("hold2", 1'b0, 5'd6, 32'h66);
    checkReady("hold2", 1'b0, 1'b0);
    @(negedge clk);
    checkWrite("hold3", 1'b0, 5'd6, 32'h66);
    hold = 1'b0;
    #1 checkReady("postHold", 1'b0, 1'b1);
    @(negedge clk);
    checkWrite("postHold", 1'b1, 5'd2, 32'h77);
    bValid = 1'b0;
    #1 checkReady("postHoldA", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("postHoldA", 1'b1, 5'd8, 32'h88);

    // Same destination r7 with prio=B
    applyStimulus(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0);
    #1 checkReady("sameDst1", 1'b0, 1'b1);
    @(negedge clk);
    checkWrite("sameDst1", 1'b1, 5'd7, 32'h2);
    bValid = 1'b0;
    #1 checkReady("sameDst2", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("sameDst2", 1'b1, 5'd7, 32'h1);

    // Back-to-back A including a write to r0
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkReady("reg0", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("reg0", 1'b1, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    #1 checkReady("b2b", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("b2b", 1'b1, 5'd9, 32'hDEAD_BEEF);

    // Bypass lookup against the committing r9 write
    fwdAddr1 = 5'd9;
    fwdAddr2 = 5'd8;
    #1;
`ifdef WB_FWD_EN
    checkOutput("fwdHit1", {31'd0, fwdHit1}, 32'd1);
    checkOutput("fwdData1", fwdData1, 32'hDEAD_BEEF);
`else
    checkOutput("fwdHit1", {31'd0, fwdHit1}, 32'd0);
    checkOutput("fwdData1", fwdData1, 32'h0);
`endif
    checkOutput("fwdHit2", {31'd0, fwdHit2}, 32'd0);
    checkOutput("fwdData2", fwdData2, 32'h0);

    // Async reset mid-write; prio was B, reset returns it to A
    applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0);
    #1 rst = 1'b1;
    #1 checkWrite("asyncRst", 1'b0, 5'd0, 32'h0);
    checkReady("asyncRst", 1'b0, 1'b0);
    checkOutput("asyncRstFwd", {31'd0, fwdHit1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkReady("afterRst", 1'b1, 1'b0);
    @(negedge clk);
    checkWrite("afterRst", 1'b1, 5'd10, 32'hA0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    checkWrite("final", 1'b0, 5'd10, 32'hA0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
